game_sequencer: RTL

//  Top-level game controller for the breakout datapath. Sequences IDLE/SERVE/PLAY/LEVEL_CLEAR/GAME_OVER.

---
 rtl/breakout_pkg.sv | 18 +
 rtl/game_sequencer_tick_gen.sv | 22 ++
 rtl/game_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared game-state encoding, board geometry, start lives and colour constants
package breakout_pkg;
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE       = 3'd1,
    PLAY        = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4,
    PAUSED      = 3'd5
  } state_t;
  localparam int NUM_BLOCKS_X = 14;
  localparam int NUM_BLOCKS_Y = 4;
  localparam logic [3:0] START_LIVES = 4'd7;
  localparam logic [11:0] COL_BG = 12'h000;
  localparam logic [11:0] COL_PADDLE = 12'hfff;
  localparam logic [11:0] COL_BALL = 12'hff0;
  localparam logic [11:0] COL_BLOCK = 12'hf80;
endpackage

// File: rtl/game_sequencer_tick_gen.sv
// tick_gen: period counter (enable freezes, clear zeroes) emitting a registered one-cycle tick each period
module tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] period,
  output logic        tick
);
  logic [31:0] cnt;
  logic        wrap;
  assign wrap = cnt == period - 32'd1;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && wrap;
      cnt  <= !en ? cnt : wrap ? '0 : cnt + 32'd1;
    end
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: breakout game FSM owning lives, level, serve delay and motion tick; PAUSE_EN enables pause
module game_sequencer
  import breakout_pkg::*;
#(
  parameter int unsigned SERVE_DELAY = 50_000_000,
  parameter int unsigned BASE_PERIOD = 750_000,
  parameter int unsigned PERIOD_STEP = 50_000,
  parameter int unsigned MIN_PERIOD  = 250_000,
  parameter int unsigned NUM_BLOCKS  = 56,
  parameter int unsigned MAX_LEVEL   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_start,
  input  logic                  btn_pause,
  input  logic                  ball_missed,
  input  logic [NUM_BLOCKS-1:0] visible,
  output logic                  move_tick,
  output logic                  ball_reset,
  output logic                  board_reload,
  output logic [3:0]            lives,
  output logic [2:0]            level,
  output logic [2:0]            game_state
);
`ifdef PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif
  localparam logic [2:0] MAX_LVL = 3'(MAX_LEVEL);
  state_t      state;
  logic        start_q, pause_q, start_press, pause_press, cleared, delay_done, tick_en, tick_clr;
  logic [31:0] dly, period, dec;
  assign game_state  = state;
  assign start_press = btn_start && !start_q;
  assign pause_press = PAUSE_ON && btn_pause && !pause_q;
  assign cleared     = ~|visible;
  assign delay_done  = dly == SERVE_DELAY - 1;
  assign dec         = {29'd0, level} * PERIOD_STEP;
  assign tick_en     = state == PLAY && !cleared && !ball_missed && !pause_press;
  assign tick_clr    = state != PLAY && state != PAUSED;
  tick_gen u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (tick_en),
    .clr    (tick_clr),
    .period (period),
    .tick   (move_tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lives        <= START_LIVES;
      level        <= '0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      dly          <= '0;
      period       <= BASE_PERIOD;
      ball_reset   <= 1'b0;
      board_reload <= 1'b0;
    end else begin
      start_q      <= btn_start;
      pause_q      <= btn_pause;
      ball_reset   <= 1'b0;
      board_reload <= 1'b0;
      dly          <= ((state == SERVE || state == LEVEL_CLEAR) && !delay_done) ? dly + 32'd1 : '0;
      period       <= (BASE_PERIOD > dec && BASE_PERIOD - dec > MIN_PERIOD) ? BASE_PERIOD - dec : MIN_PERIOD;
      case (state)
        IDLE, GAME_OVER:
          if (start_press) begin
            lives        <= START_LIVES;
            level        <= '0;
            ball_reset   <= 1'b1;
            board_reload <= 1'b1;
            state        <= SERVE;
          end
        SERVE:
          if (delay_done) state <= PLAY;
        PLAY:
          if (cleared) state <= LEVEL_CLEAR;
          else if (ball_missed) begin
            lives      <= lives - 4'd1;
            ball_reset <= lives != 4'd1;
            state      <= lives == 4'd1 ? GAME_OVER : SERVE;
          end else if (pause_press) state <= PAUSED;
        LEVEL_CLEAR:
          if (delay_done) begin
            level        <= level < MAX_LVL ? level + 3'd1 : level;
            ball_reset   <= 1'b1;
            board_reload <= 1'b1;
            state        <= SERVE;
          end
        PAUSED:
          if (pause_press) state <= PLAY;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
